// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment bit positions,
// the blank pattern and the active-high hex glyph table.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n is the g..a pattern for hex digit n; listed from F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-side and display-side signals of the scan driver, grouped so the
// board logic (master) and the driver (slave) share one bundle.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] DATA;
  logic [DIGITS-1:0]   DP_IN;
  logic                LZB;
  logic                LOAD;
  logic [7:0]          LED;
  logic [DIGITS-1:0]   SA;
  logic                FRAME;

  modport master (
    output DATA, DP_IN, LZB, LOAD,
    input  LED, SA, FRAME
  );

  modport slave (
    input  DATA, DP_IN, LZB, LOAD,
    output LED, SA, FRAME
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high a..g segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: prescaled digit scan, frame-synchronous shadow
// update, anti-ghost blanking at the start of each slot and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              CLK,
  input  logic              RST,
  seg7_scan_driver_if.slave io_bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0]     PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]     BLANK_END = PW'(BLANK);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]        LED_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SA_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_vld;
  logic [4*DIGITS-1:0] r_shd_data;
  logic [DIGITS-1:0]   r_shd_dp;
  logic                r_frame;
  logic [7:0]          r_led;
  logic [DIGITS-1:0]   r_sa;

  logic                w_wrap;
  logic                w_boundary;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_lz_blank;
  logic                w_run;
  logic [7:0]          w_led_ah;
  logic [DIGITS-1:0]   w_sa_ah;
  logic [7:0]          w_led_nxt;
  logic [DIGITS-1:0]   w_sa_nxt;

  assign w_wrap     = (r_presc == PS_LAST);
  assign w_boundary = w_wrap && (r_idx == IDX_LAST);
  assign w_nibble   = r_shd_data[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_lz_blank = '0;
    w_run      = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_run         = w_run & (r_shd_data[4*k +: 4] == 4'h0);
      w_lz_blank[k] = w_run;
    end
  end

  always_comb begin
    w_led_ah                = '0;
    w_sa_ah                 = '0;
    w_led_ah[SEG_G:SEG_A]   = (io_bus.LZB && w_lz_blank[r_idx]) ? SEG_OFF : w_seg;
    w_led_ah[SEG_DP]        = r_shd_dp[r_idx];
    w_sa_ah[r_idx]          = 1'b1;
    if (r_presc < BLANK_END) begin
      w_led_ah = '0;
      w_sa_ah  = '0;
    end
    w_led_nxt = (ACTIVE_LOW != 0) ? ~w_led_ah : w_led_ah;
    w_sa_nxt  = (ACTIVE_LOW != 0) ? ~w_sa_ah  : w_sa_ah;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_vld  <= 1'b0;
      r_shd_data  <= '0;
      r_shd_dp    <= '0;
      r_frame     <= 1'b0;
      r_led       <= LED_OFF;
      r_sa        <= SA_OFF;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      r_frame <= w_boundary;
      if (w_boundary && r_pend_vld) begin
        r_shd_data <= r_pend_data;
        r_shd_dp   <= r_pend_dp;
      end
      // A LOAD on the boundary edge lands in pending and waits for the next frame.
      if (io_bus.LOAD) begin
        r_pend_data <= io_bus.DATA;
        r_pend_dp   <= io_bus.DP_IN;
        r_pend_vld  <= 1'b1;
      end else if (w_boundary) begin
        r_pend_vld  <= 1'b0;
      end
      r_led <= w_led_nxt;
      r_sa  <= w_sa_nxt;
    end
  end

  assign io_bus.LED   = r_led;
  assign io_bus.SA    = r_sa;
  assign io_bus.FRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, PRESCALE=8, BLANK=2, active-low).
module tb_seg7_scan_driver;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic [3:0] sa;
    logic       fr;
    logic [2:0] mask;
    string      name;
  } exp_t;

  localparam logic [2:0] M_ALL = 3'b111;
  localparam logic [2:0] M_FR  = 3'b001;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS(4), .PRESCALE(8), .BLANK(2), .ACTIVE_LOW(1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus)
  );

  int   cyc = 0;
  int   base;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Absolute cycle at which the output shows frame k, digit d, slot count p.
  function automatic int at(input int k, input int d, input int p);
    return base + 32*k + 8*d + p + 1;
  endfunction

  task automatic push(input int c, input logic [7:0] led, input logic [3:0] sa,
                      input logic fr, input logic [2:0] mask, input string nm);
    exp_t e;
    e.cyc = c; e.led = led; e.sa = sa; e.fr = fr; e.mask = mask; e.name = nm;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    bus.DATA  = d;
    bus.DP_IN = dp;
    bus.LOAD  = 1'b1;
    @(posedge CLK);
    #1;
    bus.LOAD  = 1'b0;
  endtask

  // Monitor: compares every scoreboard entry whose cycle has arrived.
  always @(negedge CLK) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_chk++;
        if ((!q[i].mask[2] || bus.LED === q[i].led) &&
            (!q[i].mask[1] || bus.SA === q[i].sa) &&
            (!q[i].mask[0] || bus.FRAME === q[i].fr)) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0d: LED=%h SA=%b FRAME=%b, expected LED=%h SA=%b FRAME=%b (mask %b)",
                   q[i].name, cyc, bus.LED, bus.SA, bus.FRAME,
                   q[i].led, q[i].sa, q[i].fr, q[i].mask);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_chk++;
        $display("FAIL %s: cycle %0d never observed", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
  end

  initial begin
    RST = 1'b1;
    bus.DATA = '0; bus.DP_IN = '0; bus.LZB = 1'b0; bus.LOAD = 1'b0;
    base = 3;

    // Reset and first slot
    push(1, 8'hFF, 4'hF, 1'b0, M_ALL, "rst_edge1");
    push(3, 8'hFF, 4'hF, 1'b0, M_ALL, "rst_hold");
    push(at(0,0,0), 8'hFF, 4'hF, 1'b0, M_ALL, "blank0");
    push(at(0,0,1), 8'hFF, 4'hF, 1'b0, M_ALL, "blank1");
    push(at(0,0,2), 8'hC0, 4'hE, 1'b0, M_ALL, "first_digit0");
    push(at(0,3,5), 8'hC0, 4'h7, 1'b0, M_ALL, "zero_digit3");

    // FRAME cadence: high exactly at each boundary, low either side
    for (int k = 1; k <= 6; k++) begin
      push(base + 32*k - 1, 8'h00, 4'h0, 1'b0, M_FR, $sformatf("frame_pre_%0d", k));
      push(base + 32*k,     8'h00, 4'h0, 1'b1, M_FR, $sformatf("frame_pulse_%0d", k));
      push(base + 32*k + 1, 8'h00, 4'h0, 1'b0, M_FR, $sformatf("frame_post_%0d", k));
    end

    // Mid-frame load of 3210
    push(at(0,2,3), 8'hC0, 4'hB, 1'b0, M_ALL, "old_until_frame");
    push(at(0,3,7), 8'hC0, 4'h7, 1'b1, M_ALL, "boundary_out");
    push(at(1,0,0), 8'hFF, 4'hF, 1'b0, M_ALL, "f1_blank");
    push(at(1,0,2), 8'hC0, 4'hE, 1'b0, M_ALL, "f1_d0");
    push(at(1,1,1), 8'hFF, 4'hF, 1'b0, M_ALL, "f1_d1_blank");
    push(at(1,1,2), 8'hF9, 4'hD, 1'b0, M_ALL, "f1_d1");
    push(at(1,2,7), 8'hA4, 4'hB, 1'b0, M_ALL, "f1_d2");
    push(at(1,3,2), 8'hB0, 4'h7, 1'b0, M_ALL, "f1_d3");

    // 00A5 with leading-zero blanking, then without
    push(at(2,0,3), 8'h92, 4'hE, 1'b0, M_ALL, "lzb_d0");
    push(at(2,1,3), 8'h88, 4'hD, 1'b0, M_ALL, "lzb_d1");
    push(at(2,2,3), 8'h7F, 4'hB, 1'b0, M_ALL, "lzb_d2_dp");
    push(at(2,3,3), 8'hFF, 4'h7, 1'b0, M_ALL, "lzb_d3");
    push(at(3,0,4), 8'h92, 4'hE, 1'b0, M_ALL, "nolzb_d0");
    push(at(3,2,4), 8'h40, 4'hB, 1'b0, M_ALL, "nolzb_d2");
    push(at(3,3,4), 8'hC0, 4'h7, 1'b0, M_ALL, "nolzb_d3");

    // Load on the exact boundary edge
    push(at(3,3,7), 8'hC0, 4'h7, 1'b1, M_ALL, "edge_load_frame");
    push(at(4,0,3), 8'h92, 4'hE, 1'b0, M_ALL, "edge_load_d0_old");
    push(at(4,1,3), 8'h88, 4'hD, 1'b0, M_ALL, "edge_load_d1_old");
    push(at(4,2,3), 8'h40, 4'hB, 1'b0, M_ALL, "edge_load_d2_old");
    push(at(5,0,2), 8'h8E, 4'hE, 1'b0, M_ALL, "ffff_d0");
    push(at(5,1,2), 8'h8E, 4'hD, 1'b0, M_ALL, "ffff_d1");
    push(at(5,2,2), 8'h8E, 4'hB, 1'b0, M_ALL, "ffff_d2");
    push(at(5,3,2), 8'h8E, 4'h7, 1'b0, M_ALL, "ffff_d3");

    // Reset during slot 2 count 5 of frame 6
    push(base + 214, 8'hFF, 4'hF, 1'b0, M_ALL, "rst_midslot");

    wait_cyc(3);
    RST = 1'b0;

    wait_cyc(base + 10);
    load(16'h3210, 4'b0000);

    wait_cyc(base + 40);
    bus.LZB = 1'b1;
    load(16'h00A5, 4'b0100);

    wait_cyc(base + 96);
    bus.LZB = 1'b0;

    wait_cyc(base + 127);
    load(16'hFFFF, 4'b0000);

    wait_cyc(base + 200);
    load(16'h1111, 4'b0000);

    wait_cyc(base + 213);
    RST = 1'b1;
    wait_cyc(base + 214);
    RST = 1'b0;
    base = base + 214;

    push(at(0,0,1), 8'hFF, 4'hF, 1'b0, M_ALL, "post_rst_blank");
    push(at(0,0,2), 8'hC0, 4'hE, 1'b0, M_ALL, "post_rst_d0");
    push(base + 10, 8'h00, 4'h0, 1'b0, M_FR,  "no_stale_frame");
    push(at(0,3,7), 8'hC0, 4'h7, 1'b1, M_ALL, "post_rst_frame");
    push(at(1,0,2), 8'hC0, 4'hE, 1'b0, M_ALL, "pending_discarded_d0");
    push(at(1,1,2), 8'hC0, 4'hD, 1'b0, M_ALL, "pending_discarded_d1");

    wait_cyc(base + 80);
    while (q.size() != 0) begin
      n_chk++;
      $display("FAIL %s: entry for cycle %0d left unchecked", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
